// File: rtl/axi_wr_burst_packer.sv
// rtl/axi_wr_burst_packer.sv - packs user words into AXI beats, buffers them in a FIFO and issues write bursts
module axi_wr_burst_packer #(
  parameter int USER_WR_DATA_WIDTH = 16,
  parameter int AXI_DATA_WIDTH     = 128,
  parameter int AXI_ADDR_WIDTH     = 32,
  parameter int WR_BURST_LENGTH    = 4096,
  parameter int FIFO_DEPTH         = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ddr_init_done,
  input  logic                          user_wr_en,
  input  logic [USER_WR_DATA_WIDTH-1:0] user_wr_data,
  input  logic                          user_wr_flush,
  input  logic [AXI_ADDR_WIDTH-1:0]     user_wr_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0]     user_wr_end_addr,
  output logic                          wr_req_en,
  input  logic                          wr_req_ready,
  output logic [7:0]                    wr_burst_length,
  output logic [AXI_ADDR_WIDTH-1:0]     wr_data_addr,
  output logic [AXI_DATA_WIDTH-1:0]     wr_data_out,
  output logic                          wr_data_valid,
  input  logic                          wr_data_ready,
  output logic                          wr_data_last,
  output logic                          wr_overflow,
  output logic                          wr_busy
);
  localparam int NUM_WORDS  = AXI_DATA_WIDTH / USER_WR_DATA_WIDTH;
  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int MAX_BEATS  = WR_BURST_LENGTH / BEAT_BYTES;
  localparam int WC_W       = $clog2(NUM_WORDS + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int SH_W       = $clog2(AXI_DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                init_sync_q, init_sync_d;
  logic [AXI_DATA_WIDTH-1:0] beat_q, beat_d;
  logic [WC_W-1:0]           word_cnt_q, word_cnt_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          fifo_count_q, fifo_count_d;
  logic                      flush_pending_q, flush_pending_d;
  logic                      overflow_q, overflow_d;
  logic [7:0]                burst_len_q, burst_len_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic                      word_acc, push, push_ok, pop, fifo_full, wrap;
  logic [WC_W-1:0]           words_now;
  logic [SH_W-1:0]           pad_shift;
  logic [AXI_DATA_WIDTH-1:0] beat_shift, push_data;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;

  always_comb begin
    init_sync_d = {init_sync_q[0], ddr_init_done};
    word_acc    = user_wr_en && init_sync_q[1];
    // New words enter at the top so the first word of a beat ends at the bottom
    beat_shift  = word_acc ? AXI_DATA_WIDTH'({user_wr_data, beat_q} >> USER_WR_DATA_WIDTH) : beat_q;
    words_now   = word_cnt_q + WC_W'(word_acc);
    pad_shift   = SH_W'(NUM_WORDS - int'(words_now)) * SH_W'(USER_WR_DATA_WIDTH);
    beat_d      = beat_shift;
    word_cnt_d  = words_now;
    push        = 1'b0;
    push_data   = beat_shift;
    if (words_now == WC_W'(NUM_WORDS)) begin
      push       = 1'b1;
      word_cnt_d = '0;
    end else if (user_wr_flush && words_now != '0) begin
      push       = 1'b1;
      push_data  = beat_shift >> pad_shift;
      word_cnt_d = '0;
    end

    fifo_full    = fifo_count_q == CNT_W'(FIFO_DEPTH);
    pop          = (state_q == DATA) && wr_data_ready;
    push_ok      = push && (!fifo_full || pop);
    overflow_d   = overflow_q || (push && !push_ok);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    fifo_count_d = fifo_count_q + CNT_W'(push_ok) - CNT_W'(pop);

    flush_pending_d = flush_pending_q;
    if (user_wr_flush) flush_pending_d = 1'b1;
    else if (state_q == IDLE && fifo_count_q == '0) flush_pending_d = 1'b0;

    next_addr   = addr_q + (AXI_ADDR_WIDTH'(burst_len_q) + AXI_ADDR_WIDTH'(1)) * AXI_ADDR_WIDTH'(BEAT_BYTES);
    wrap        = ({1'b0, next_addr} + (AXI_ADDR_WIDTH+1)'(WR_BURST_LENGTH)) > {1'b0, user_wr_end_addr};
    state_d     = state_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    case (state_q)
      IDLE: begin
        if (fifo_count_q >= CNT_W'(MAX_BEATS)) begin
          state_d     = REQ;
          burst_len_d = 8'(MAX_BEATS - 1);
        end else if (flush_pending_q && fifo_count_q != '0) begin
          state_d     = REQ;
          burst_len_d = 8'(fifo_count_q - CNT_W'(1));
        end
      end
      REQ: begin
        if (wr_req_ready) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        if (wr_data_ready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == burst_len_q) begin
            state_d = IDLE;
            addr_d  = wrap ? user_wr_base_addr : next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      init_sync_q     <= '0;
      beat_q          <= '0;
      word_cnt_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      burst_len_q     <= '0;
      beat_cnt_q      <= '0;
      addr_q          <= user_wr_base_addr;
    end else begin
      state_q         <= state_d;
      init_sync_q     <= init_sync_d;
      beat_q          <= beat_d;
      word_cnt_q      <= word_cnt_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      burst_len_q     <= burst_len_d;
      beat_cnt_q      <= beat_cnt_d;
      addr_q          <= addr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= push_data;
  end

  assign wr_req_en       = state_q == REQ;
  assign wr_burst_length = burst_len_q;
  assign wr_data_addr    = addr_q;
  assign wr_data_valid   = state_q == DATA;
  assign wr_data_last    = (state_q == DATA) && (beat_cnt_q == burst_len_q);
  assign wr_data_out     = (state_q == DATA) ? fifo_mem_q[rd_ptr_q] : '0;
  assign wr_overflow     = overflow_q;
  assign wr_busy         = (state_q != IDLE) || flush_pending_q;
endmodule

// File: tb/tb_axi_wr_burst_packer.sv
// tb/tb_axi_wr_burst_packer.sv - directed self-checking bench for axi_wr_burst_packer
module tb_axi_wr_burst_packer;
  logic         clk = 1'b0;
  logic         reset, ddr_init_done, user_wr_en, user_wr_flush;
  logic [15:0]  user_wr_data;
  logic [31:0]  user_wr_base_addr, user_wr_end_addr;
  logic         wr_req_en, wr_req_ready, wr_data_valid, wr_data_ready, wr_data_last;
  logic         wr_overflow, wr_busy;
  logic [7:0]   wr_burst_length;
  logic [31:0]  wr_data_addr;
  logic [127:0] wr_data_out;

  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  logic [128:0] beat_q [$];
  logic [39:0]  req_q [$];
  int stall_err = 0, req_err = 0, req_wait = 0;
  logic         prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic         prev_req = 1'b0, prev_req_ready = 1'b0;
  logic [127:0] prev_data = '0;
  logic [31:0]  prev_addr = '0;
  logic [7:0]   prev_len = '0;

  always #5 clk = ~clk;

  axi_wr_burst_packer dut (
    .clk(clk), .reset(reset), .ddr_init_done(ddr_init_done),
    .user_wr_en(user_wr_en), .user_wr_data(user_wr_data), .user_wr_flush(user_wr_flush),
    .user_wr_base_addr(user_wr_base_addr), .user_wr_end_addr(user_wr_end_addr),
    .wr_req_en(wr_req_en), .wr_req_ready(wr_req_ready), .wr_burst_length(wr_burst_length),
    .wr_data_addr(wr_data_addr), .wr_data_out(wr_data_out), .wr_data_valid(wr_data_valid),
    .wr_data_ready(wr_data_ready), .wr_data_last(wr_data_last),
    .wr_overflow(wr_overflow), .wr_busy(wr_busy)
  );

  // Observer: records handshakes and counts protocol hold violations
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_valid <= 1'b0;
      prev_req   <= 1'b0;
    end else begin
      if (prev_valid && !prev_ready &&
          (wr_data_valid !== 1'b1 || wr_data_out !== prev_data || wr_data_last !== prev_last))
        stall_err <= stall_err + 1;
      if (prev_req && !prev_req_ready &&
          (wr_req_en !== 1'b1 || wr_data_addr !== prev_addr || wr_burst_length !== prev_len))
        req_err <= req_err + 1;
      if (wr_req_en && !wr_req_ready) req_wait <= req_wait + 1;
      if (wr_req_en && wr_req_ready) req_q.push_back({wr_data_addr, wr_burst_length});
      if (wr_data_valid && wr_data_ready) beat_q.push_back({wr_data_last, wr_data_out});
      prev_valid     <= wr_data_valid;
      prev_ready     <= wr_data_ready;
      prev_data      <= wr_data_out;
      prev_last      <= wr_data_last;
      prev_req       <= wr_req_en;
      prev_req_ready <= wr_req_ready;
      prev_addr      <= wr_data_addr;
      prev_len       <= wr_burst_length;
    end
  end

  function automatic logic [127:0] exp_beat(input int first, input int i);
    logic [127:0] b;
    for (int k = 0; k < 8; k++) b[k*16 +: 16] = 16'(first + i*8 + k);
    return b;
  endfunction

  task automatic do_reset(input logic [31:0] base, input logic [31:0] end_a);
    user_wr_base_addr = base;
    user_wr_end_addr  = end_a;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic write_words(input int first, input int n, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      user_wr_en    = 1'b1;
      user_wr_data  = 16'(first + i);
      user_wr_flush = flush_last && (i == n - 1);
      @(posedge clk);
      #2;
    end
    user_wr_en    = 1'b0;
    user_wr_flush = 1'b0;
  endtask

  task automatic wait_beats(input int b0, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (beat_q.size() - b0 >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    do_reset(32'h0, 32'h10000);
    @(negedge clk);
    n_checks++; if (wr_req_en !== 1'b0) $display("FAIL reset_req_en: got %0h want 0", wr_req_en); else n_pass++;
    n_checks++; if (wr_burst_length !== 8'h0) $display("FAIL reset_len: got %0h want 0", wr_burst_length); else n_pass++;
    n_checks++; if (wr_data_addr !== 32'h0) $display("FAIL reset_addr: got %0h want 0", wr_data_addr); else n_pass++;
    n_checks++; if (wr_data_out !== 128'h0) $display("FAIL reset_data: got %0h want 0", wr_data_out); else n_pass++;
    n_checks++; if (wr_data_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", wr_data_valid); else n_pass++;
    n_checks++; if (wr_data_last !== 1'b0) $display("FAIL reset_last: got %0h want 0", wr_data_last); else n_pass++;
    n_checks++; if (wr_overflow !== 1'b0) $display("FAIL reset_overflow: got %0h want 0", wr_overflow); else n_pass++;
    n_checks++; if (wr_busy !== 1'b0) $display("FAIL reset_busy: got %0h want 0", wr_busy); else n_pass++;
  endtask

  task automatic test_full_burst;
    int b0, r0, err, lerr;
    bit ok;
    do_reset(32'h0, 32'h10000);
    b0 = beat_q.size(); r0 = req_q.size();
    write_words(0, 2048, 1'b0);
    @(negedge clk);
    n_checks++; if (wr_req_en !== 1'b0) $display("FAIL full_req_t1: got %0h want 0", wr_req_en); else n_pass++;
    @(negedge clk);
    n_checks++; if (wr_req_en !== 1'b1) $display("FAIL full_req_t2: got %0h want 1", wr_req_en); else n_pass++;
    wait_beats(b0, 256, 2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL full_timeout: got %0d beats want 256", beat_q.size() - b0); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (req_q.size() - r0 !== 1) $display("FAIL full_req_count: got %0d want 1", req_q.size() - r0); else n_pass++;
    if (req_q.size() > r0) begin
      n_checks++; if (req_q[r0] !== {32'h0, 8'd255}) $display("FAIL full_req: got %0h want %0h", req_q[r0], {32'h0, 8'd255}); else n_pass++;
    end
    n_checks++; if (beat_q.size() - b0 !== 256) $display("FAIL full_beat_count: got %0d want 256", beat_q.size() - b0); else n_pass++;
    if (beat_q.size() > b0) begin
      n_checks++;
      if (beat_q[b0][127:0] !== 128'h0007_0006_0005_0004_0003_0002_0001_0000)
        $display("FAIL full_beat0: got %0h want 00070006000500040003000200010000", beat_q[b0][127:0]);
      else n_pass++;
    end
    err = 0; lerr = 0;
    for (int i = 0; i < beat_q.size() - b0; i++) begin
      if (beat_q[b0+i][127:0] !== exp_beat(0, i)) err++;
      if (beat_q[b0+i][128] !== (i == 255)) lerr++;
    end
    n_checks++; if (err !== 0) $display("FAIL full_data: got %0d bad beats want 0", err); else n_pass++;
    n_checks++; if (lerr !== 0) $display("FAIL full_last: got %0d bad last flags want 0", lerr); else n_pass++;
    n_checks++; if (wr_busy !== 1'b0) $display("FAIL full_busy_end: got %0h want 0", wr_busy); else n_pass++;
  endtask

  task automatic test_backpressure;
    int b0, r0, s_stall, s_req, s_wait, err;
    bit ok;
    do_reset(32'h0, 32'h10000);
    b0 = beat_q.size(); r0 = req_q.size();
    s_stall = stall_err; s_req = req_err; s_wait = req_wait;
    wr_req_ready = 1'b0; wr_data_ready = 1'b0;
    write_words(0, 2048, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wr_req_en === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_req_seen: got %0h want 1", ok); else n_pass++;
    repeat (10) @(posedge clk);
    #2 wr_req_ready = 1'b1;
    for (int c = 0; c < 3000 && beat_q.size() - b0 < 256; c++) begin
      @(posedge clk);
      #2 wr_data_ready = ~wr_data_ready;
    end
    wr_data_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (req_wait - s_wait !== 10) $display("FAIL bp_req_hold: got %0d cycles want 10", req_wait - s_wait); else n_pass++;
    n_checks++; if (req_err - s_req !== 0) $display("FAIL bp_req_stable: got %0d changes want 0", req_err - s_req); else n_pass++;
    n_checks++; if (stall_err - s_stall !== 0) $display("FAIL bp_data_hold: got %0d changes want 0", stall_err - s_stall); else n_pass++;
    n_checks++; if (req_q.size() - r0 !== 1) $display("FAIL bp_req_count: got %0d want 1", req_q.size() - r0); else n_pass++;
    n_checks++; if (beat_q.size() - b0 !== 256) $display("FAIL bp_beat_count: got %0d want 256", beat_q.size() - b0); else n_pass++;
    err = 0;
    for (int i = 0; i < beat_q.size() - b0; i++)
      if (beat_q[b0+i] !== {i == 255, exp_beat(0, i)}) err++;
    n_checks++; if (err !== 0) $display("FAIL bp_data: got %0d bad beats want 0", err); else n_pass++;
  endtask

  task automatic test_flush;
    int b0, r0;
    bit ok;
    do_reset(32'h0, 32'h10000);
    b0 = beat_q.size(); r0 = req_q.size();
    write_words(0, 20, 1'b0);
    user_wr_flush = 1'b1;
    @(posedge clk);
    #2 user_wr_flush = 1'b0;
    wait_beats(b0, 3, 200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL flush_timeout: got %0d beats want 3", beat_q.size() - b0); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (req_q.size() - r0 !== 1) $display("FAIL flush_req_count: got %0d want 1", req_q.size() - r0); else n_pass++;
    if (req_q.size() > r0) begin
      n_checks++; if (req_q[r0] !== {32'h0, 8'd2}) $display("FAIL flush_req: got %0h want %0h", req_q[r0], {32'h0, 8'd2}); else n_pass++;
    end
    if (beat_q.size() - b0 == 3) begin
      n_checks++; if (beat_q[b0] !== {1'b0, exp_beat(0, 0)}) $display("FAIL flush_beat0: got %0h want %0h", beat_q[b0], {1'b0, exp_beat(0, 0)}); else n_pass++;
      n_checks++; if (beat_q[b0+1] !== {1'b0, exp_beat(0, 1)}) $display("FAIL flush_beat1: got %0h want %0h", beat_q[b0+1], {1'b0, exp_beat(0, 1)}); else n_pass++;
      n_checks++;
      if (beat_q[b0+2] !== {1'b1, 64'h0, 64'h0013_0012_0011_0010})
        $display("FAIL flush_beat2: got %0h want 1_0000000000000000_0013001200110010", beat_q[b0+2]);
      else n_pass++;
    end
    n_checks++; if (wr_busy !== 1'b0) $display("FAIL flush_busy: got %0h want 0", wr_busy); else n_pass++;
    n_checks++; if (wr_data_addr !== 32'd48) $display("FAIL flush_next_addr: got %0h want 30", wr_data_addr); else n_pass++;
    // Word and flush together: three words form a single padded beat
    b0 = beat_q.size(); r0 = req_q.size();
    write_words(16'h0100, 3, 1'b1);
    wait_beats(b0, 1, 200, ok);
    repeat (5) @(negedge clk);
    n_checks++; if (req_q.size() - r0 !== 1) $display("FAIL flush1_req_count: got %0d want 1", req_q.size() - r0); else n_pass++;
    if (req_q.size() > r0) begin
      n_checks++; if (req_q[r0] !== {32'd48, 8'd0}) $display("FAIL flush1_req: got %0h want %0h", req_q[r0], {32'd48, 8'd0}); else n_pass++;
    end
    n_checks++; if (beat_q.size() - b0 !== 1) $display("FAIL flush1_beat_count: got %0d want 1", beat_q.size() - b0); else n_pass++;
    if (beat_q.size() > b0) begin
      n_checks++;
      if (beat_q[b0] !== {1'b1, 80'h0, 48'h0102_0101_0100})
        $display("FAIL flush1_beat: got %0h want 1_00000000000000000000_010201010100", beat_q[b0]);
      else n_pass++;
    end
    n_checks++; if (wr_data_addr !== 32'd64) $display("FAIL flush1_next_addr: got %0h want 40", wr_data_addr); else n_pass++;
  endtask

  task automatic test_wrap;
    int b0, r0;
    bit ok;
    do_reset(32'h1000, 32'h3000);
    @(negedge clk);
    n_checks++; if (wr_data_addr !== 32'h1000) $display("FAIL wrap_reset_addr: got %0h want 1000", wr_data_addr); else n_pass++;
    b0 = beat_q.size(); r0 = req_q.size();
    write_words(0, 6144, 1'b0);
    wait_beats(b0, 768, 2000, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (req_q.size() - r0 !== 3) $display("FAIL wrap_req_count: got %0d want 3", req_q.size() - r0); else n_pass++;
    if (req_q.size() - r0 == 3) begin
      n_checks++; if (req_q[r0] !== {32'h1000, 8'd255}) $display("FAIL wrap_req0: got %0h want %0h", req_q[r0], {32'h1000, 8'd255}); else n_pass++;
      n_checks++; if (req_q[r0+1] !== {32'h2000, 8'd255}) $display("FAIL wrap_req1: got %0h want %0h", req_q[r0+1], {32'h2000, 8'd255}); else n_pass++;
      n_checks++; if (req_q[r0+2] !== {32'h1000, 8'd255}) $display("FAIL wrap_req2: got %0h want %0h", req_q[r0+2], {32'h1000, 8'd255}); else n_pass++;
    end
  endtask

  task automatic test_overflow;
    int b0, r0, err;
    bit ok;
    do_reset(32'h0, 32'h10000);
    b0 = beat_q.size(); r0 = req_q.size();
    ddr_init_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 write_words(16'h0500, 16, 1'b0);
    ddr_init_done = 1'b1;
    repeat (3) @(posedge clk);
    #2 user_wr_flush = 1'b1;
    @(posedge clk);
    #2 user_wr_flush = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (beat_q.size() - b0 !== 0) $display("FAIL gate_beats: got %0d want 0", beat_q.size() - b0); else n_pass++;
    n_checks++; if (wr_req_en !== 1'b0) $display("FAIL gate_req: got %0h want 0", wr_req_en); else n_pass++;
    wr_req_ready = 1'b0;
    write_words(0, 4096, 1'b0);
    @(negedge clk);
    n_checks++; if (wr_overflow !== 1'b0) $display("FAIL ovf_512: got %0h want 0", wr_overflow); else n_pass++;
    write_words(4096, 8, 1'b0);
    @(negedge clk);
    n_checks++; if (wr_overflow !== 1'b1) $display("FAIL ovf_513: got %0h want 1", wr_overflow); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (wr_overflow !== 1'b1) $display("FAIL ovf_sticky: got %0h want 1", wr_overflow); else n_pass++;
    wr_req_ready = 1'b1;
    wait_beats(b0, 512, 2000, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (beat_q.size() - b0 !== 512) $display("FAIL ovf_beat_count: got %0d want 512", beat_q.size() - b0); else n_pass++;
    err = 0;
    for (int i = 0; i < beat_q.size() - b0; i++)
      if (beat_q[b0+i] !== {(i % 256) == 255, exp_beat(0, i)}) err++;
    n_checks++; if (err !== 0) $display("FAIL ovf_data: got %0d bad beats want 0", err); else n_pass++;
    n_checks++; if (req_q.size() - r0 !== 2) $display("FAIL ovf_req_count: got %0d want 2", req_q.size() - r0); else n_pass++;
    if (req_q.size() - r0 == 2) begin
      n_checks++; if (req_q[r0+1] !== {32'h1000, 8'd255}) $display("FAIL ovf_req1: got %0h want %0h", req_q[r0+1], {32'h1000, 8'd255}); else n_pass++;
    end
    n_checks++; if (wr_overflow !== 1'b1) $display("FAIL ovf_after_drain: got %0h want 1", wr_overflow); else n_pass++;
  endtask

  task automatic test_reset_mid_burst;
    int b0, r0, err;
    bit ok;
    do_reset(32'h0, 32'h10000);
    b0 = beat_q.size();
    write_words(0, 2048, 1'b0);
    wait_beats(b0, 100, 2000, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL mid_timeout: got %0d beats want 100", beat_q.size() - b0); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (wr_req_en !== 1'b0) $display("FAIL mid_req_en: got %0h want 0", wr_req_en); else n_pass++;
    n_checks++; if (wr_burst_length !== 8'h0) $display("FAIL mid_len: got %0h want 0", wr_burst_length); else n_pass++;
    n_checks++; if (wr_data_addr !== 32'h0) $display("FAIL mid_addr: got %0h want 0", wr_data_addr); else n_pass++;
    n_checks++; if (wr_data_out !== 128'h0) $display("FAIL mid_data: got %0h want 0", wr_data_out); else n_pass++;
    n_checks++; if (wr_data_valid !== 1'b0) $display("FAIL mid_valid: got %0h want 0", wr_data_valid); else n_pass++;
    n_checks++; if (wr_data_last !== 1'b0) $display("FAIL mid_last: got %0h want 0", wr_data_last); else n_pass++;
    n_checks++; if (wr_busy !== 1'b0) $display("FAIL mid_busy: got %0h want 0", wr_busy); else n_pass++;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    b0 = beat_q.size(); r0 = req_q.size();
    write_words(16'h4000, 2048, 1'b0);
    wait_beats(b0, 256, 2000, ok);
    repeat (10) @(negedge clk);
    n_checks++; if (req_q.size() - r0 !== 1) $display("FAIL mid_req_count: got %0d want 1", req_q.size() - r0); else n_pass++;
    if (req_q.size() > r0) begin
      n_checks++; if (req_q[r0] !== {32'h0, 8'd255}) $display("FAIL mid_restart_req: got %0h want %0h", req_q[r0], {32'h0, 8'd255}); else n_pass++;
    end
    err = 0;
    for (int i = 0; i < beat_q.size() - b0; i++)
      if (beat_q[b0+i] !== {i == 255, exp_beat(16'h4000, i)}) err++;
    n_checks++; if (beat_q.size() - b0 !== 256) $display("FAIL mid_beat_count: got %0d want 256", beat_q.size() - b0); else n_pass++;
    n_checks++; if (err !== 0) $display("FAIL mid_data_restart: got %0d bad beats want 0", err); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; ddr_init_done = 1'b1; user_wr_en = 1'b0; user_wr_flush = 1'b0;
    user_wr_data = '0; user_wr_base_addr = '0; user_wr_end_addr = 32'h10000;
    wr_req_ready = 1'b1; wr_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    test_reset();
    test_full_burst();
    test_backpressure();
    test_flush();
    test_wrap();
    test_overflow();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
